axi4_burst_master: RTL and testbench

AXI4_BURST_MASTER -- requirements
Module: axi4_burst_master

---
 rtl/axi4_burst_master.sv | 179 +++++++++++++++++
 tb/tb_axi4_burst_master.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_master.sv
// AXI4 single-outstanding burst master: AW/AR issued the cycle after command accept, W through a one-entry holding register.
// Backpressure: cmd_ready only when idle; wr_ready follows W-slot availability; rd_* is a combinational pass-through of R.
`timescale 1ns/1ps
module axi4_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  rd_ready,
  output logic                  done,
  output logic [1:0]            resp,
  output logic                  len_err,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  localparam logic [2:0] AXSIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] len_q;
  logic [7:0] beat_cnt;
  logic [8:0] load_cnt;
  logic       accept, w_load, w_hs, b_hs, r_hs;

  assign AWSIZE = AXSIZE;
  assign ARSIZE = AXSIZE;
  assign rd_data = RDATA;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    BREADY    = 1'b0;
    RREADY    = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = cmd_write ? WR_ADDR : RD_ADDR;
      end
      WR_ADDR: if (AWVALID && AWREADY) state_nxt = WR_DATA;
      WR_DATA: begin
        // Refill the holding slot in the same cycle it drains, but never past the last beat.
        wr_ready = (!WVALID || WREADY) && (load_cnt < ({1'b0, len_q} + 9'd1));
        if (WVALID && WREADY && WLAST) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        BREADY = 1'b1;
        if (BVALID) state_nxt = IDLE;
      end
      RD_ADDR: if (ARVALID && ARREADY) state_nxt = RD_DATA;
      RD_DATA: begin
        RREADY   = rd_ready;
        rd_valid = RVALID;
        rd_last  = RLAST;
        if (RVALID && rd_ready && RLAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = cmd_valid && cmd_ready;
  assign w_load = wr_valid && wr_ready;
  assign w_hs   = WVALID && WREADY;
  assign b_hs   = BVALID && BREADY;
  assign r_hs   = RVALID && RREADY;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      len_q    <= '0;
      beat_cnt <= '0;
      load_cnt <= '0;
      AWADDR   <= '0;
      AWLEN    <= '0;
      AWVALID  <= 1'b0;
      ARADDR   <= '0;
      ARLEN    <= '0;
      ARVALID  <= 1'b0;
      WDATA    <= '0;
      WLAST    <= 1'b0;
      WVALID   <= 1'b0;
      done     <= 1'b0;
      resp     <= 2'b00;
      len_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        len_q    <= cmd_len;
        beat_cnt <= '0;
        load_cnt <= '0;
        resp     <= 2'b00;
        len_err  <= 1'b0;
        if (cmd_write) begin
          AWADDR  <= cmd_addr;
          AWLEN   <= cmd_len;
          AWVALID <= 1'b1;
        end else begin
          ARADDR  <= cmd_addr;
          ARLEN   <= cmd_len;
          ARVALID <= 1'b1;
        end
      end
      if (AWVALID && AWREADY) AWVALID <= 1'b0;
      if (ARVALID && ARREADY) ARVALID <= 1'b0;

      // Beats load in order, so the load index equals the W handshake index.
      if (w_load) begin
        WDATA    <= wr_data;
        WVALID   <= 1'b1;
        WLAST    <= (load_cnt == {1'b0, len_q});
        load_cnt <= load_cnt + 9'd1;
      end else if (w_hs) begin
        WVALID <= 1'b0;
        WLAST  <= 1'b0;
      end
      if (w_hs) beat_cnt <= beat_cnt + 8'd1;

      if (b_hs) begin
        resp <= BRESP;
        done <= 1'b1;
      end

      if (r_hs) begin
        if (RRESP > resp) resp <= RRESP;
        if (RLAST) begin
          done <= 1'b1;
          if (beat_cnt != len_q) len_err <= 1'b1;
        end else begin
          // Slave overran the requested length: flag it and keep draining until RLAST.
          if (beat_cnt == len_q) len_err <= 1'b1;
          if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Randomised bench for axi4_burst_master: planned bursts feed expectation queues, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_axi4_burst_master;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_len = '0;
  logic [DW-1:0] wr_data, rd_data;
  logic          wr_valid, wr_ready, rd_valid, rd_last, rd_ready;
  logic          done, len_err;
  logic [1:0]    resp;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [7:0]    AWLEN, ARLEN;
  logic [2:0]    AWSIZE, ARSIZE;
  logic          AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [1:0]    BRESP, RRESP;

  axi4_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .done(done), .resp(resp), .len_err(len_err),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expectations and slave-side stimulus
  logic [AW+7:0] exp_aw[$], exp_ar[$];
  logic [DW:0]   exp_w[$], exp_rd[$];
  logic [2:0]    exp_done[$];
  logic [DW-1:0] wr_q[$];
  logic [1:0]    bresp_q[$];
  logic [DW+2:0] rq[$];
  bit            all_ready = 1'b0;
  int            aw_stall = 0;
  int            w_hs_cnt = 0;
  logic [2:0]    last_status = 3'b000;
  logic [2:0]    pending_status = 3'b000;

  // Monitor / scoreboard
  initial begin
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_done;
    logic [AW+7:0] p_aw, p_ar;
    logic [DW:0]   p_w;
    {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_done} = '0;
    p_aw = '0; p_ar = '0; p_w = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_done} = '0;
      end else begin
        if (p_awv && !p_awr) chk("aw_hold", {AWVALID, AWADDR, AWLEN}, {1'b1, p_aw});
        if (p_arv && !p_arr) chk("ar_hold", {ARVALID, ARADDR, ARLEN}, {1'b1, p_ar});
        if (p_wv && !p_wr)   chk("w_hold", {WVALID, WDATA, WLAST}, {1'b1, p_w});
        if (AWVALID) chk("w_before_aw", WVALID, 0);
        if (AWVALID && AWREADY) begin
          if (exp_aw.size() == 0) chk("aw_unexpected", AWVALID, 0);
          else chk("aw_fields", {AWADDR, AWLEN, AWSIZE}, {exp_aw.pop_front(), 3'd2});
        end
        if (ARVALID && ARREADY) begin
          if (exp_ar.size() == 0) chk("ar_unexpected", ARVALID, 0);
          else chk("ar_fields", {ARADDR, ARLEN, ARSIZE}, {exp_ar.pop_front(), 3'd2});
        end
        if (WVALID && WREADY) begin
          w_hs_cnt++;
          if (exp_w.size() == 0) chk("w_unexpected", WVALID, 0);
          else chk("w_beat", {WDATA, WLAST}, exp_w.pop_front());
        end
        if (rd_valid && rd_ready) begin
          if (exp_rd.size() == 0) chk("rd_unexpected", rd_valid, 0);
          else chk("rd_beat", {rd_data, rd_last}, exp_rd.pop_front());
        end
        if (done) begin
          chk("done_single", p_done, 0);
          if (exp_done.size() == 0) chk("done_unexpected", done, 0);
          else chk("done_status", {resp, len_err}, exp_done.pop_front());
        end
        p_awv = AWVALID; p_awr = AWREADY; p_aw = {AWADDR, AWLEN};
        p_arv = ARVALID; p_arr = ARREADY; p_ar = {ARADDR, ARLEN};
        p_wv = WVALID;   p_wr = WREADY;   p_w = {WDATA, WLAST};
        p_done = done;
      end
    end
  end

  // Slave and write-source model: handshakes sampled at negedge, drives updated just after posedge
  initial begin
    bit aw_hs, wl_hs, b_hs, ar_hs, r_hs, wr_hs, b_pend, r_go;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0;
    RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;
    b_pend = 0; r_go = 0;
    forever begin
      @(negedge ACLK);
      aw_hs = AWVALID && AWREADY;
      wl_hs = WVALID && WREADY && WLAST;
      b_hs  = BVALID && BREADY;
      ar_hs = ARVALID && ARREADY;
      r_hs  = RVALID && RREADY;
      wr_hs = wr_valid && wr_ready;
      @(posedge ACLK); #1;
      if (!ARESETn) begin
        wr_q.delete(); rq.delete(); bresp_q.delete();
        wr_valid = 0; RVALID = 0; BVALID = 0; b_pend = 0; r_go = 0; aw_stall = 0;
      end else begin
        if (wr_hs) begin void'(wr_q.pop_front()); wr_valid = 0; end
        if (!wr_valid && wr_q.size() > 0 && (all_ready || $urandom_range(0, 3) != 0)) begin
          wr_valid = 1; wr_data = wr_q[0];
        end
        rd_ready = all_ready || ($urandom_range(0, 2) != 0);
        if (aw_stall > 0) begin
          AWREADY = 0;
          if (AWVALID) aw_stall--;
        end else AWREADY = all_ready || ($urandom_range(0, 1) != 0);
        WREADY  = all_ready || ($urandom_range(0, 3) != 0);
        ARREADY = all_ready || ($urandom_range(0, 1) != 0);
        if (aw_hs) r_go = 0;
        if (wl_hs) b_pend = 1;
        if (b_hs) begin
          if (bresp_q.size() > 0) void'(bresp_q.pop_front());
          BVALID = 0; b_pend = 0;
        end
        if (b_pend && !BVALID && bresp_q.size() > 0 && (all_ready || $urandom_range(0, 2) == 0)) begin
          BVALID = 1; BRESP = bresp_q[0];
        end
        if (ar_hs) r_go = 1;
        if (r_hs) begin
          if (rq.size() > 0) void'(rq.pop_front());
          RVALID = 0;
          if (rq.size() == 0) r_go = 0;
        end
        if (r_go && !RVALID && rq.size() > 0 && (all_ready || $urandom_range(0, 2) != 0)) begin
          RVALID = 1; {RDATA, RRESP, RLAST} = rq[0];
        end
      end
    end
  end

  task automatic plan_write(input logic [AW-1:0] a, input logic [7:0] len, input bit fixed_data,
                            input logic [1:0] br);
    logic [DW-1:0] d;
    exp_aw.push_back({a, len});
    for (int i = 0; i <= int'(len); i++) begin
      d = fixed_data ? DW'(32'hA0 + i) : DW'($urandom);
      wr_q.push_back(d);
      exp_w.push_back({d, i == int'(len)});
    end
    bresp_q.push_back(br);
    pending_status = {br, 1'b0};
    exp_done.push_back(pending_status);
  endtask

  // Slave returns beats 0..last_idx with RLAST on last_idx; burst status is worst RRESP plus length mismatch.
  task automatic plan_read(input logic [AW-1:0] a, input logic [7:0] len, input int last_idx,
                           input bit use_fixed, input logic [31:0] fixed_r);
    logic [DW-1:0] d;
    logic [1:0]    r, worst;
    worst = 2'b00;
    exp_ar.push_back({a, len});
    for (int i = 0; i <= last_idx; i++) begin
      d = DW'($urandom);
      if (use_fixed) r = fixed_r[2*i +: 2];
      else r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      if (r > worst) worst = r;
      rq.push_back({d, r, i == last_idx});
      exp_rd.push_back({d, i == last_idx});
    end
    pending_status = {worst, last_idx != int'(len)};
    exp_done.push_back(pending_status);
  endtask

  task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [7:0] len);
    int t = 0;
    @(posedge ACLK); #1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = len;
    @(negedge ACLK);
    while (!cmd_ready && t < 100) begin @(negedge ACLK); t++; end
    chk("cmd_accept", cmd_ready, 1);
    chk("status_hold", {resp, len_err}, last_status);
    @(posedge ACLK); #1;
    chk("status_clear", {resp, len_err}, 0);
    // Junk command held while busy; it must be ignored.
    cmd_valid = ($urandom_range(0, 1) != 0); cmd_write = ($urandom_range(0, 1) != 0);
    cmd_addr = AW'($urandom); cmd_len = 8'($urandom);
  endtask

  task automatic wait_done();
    int t = 0;
    bit busy_rdy = 0;
    @(negedge ACLK);
    while (!done && t < 1000) begin
      if (cmd_ready) busy_rdy = 1;
      @(negedge ACLK);
      t++;
    end
    cmd_valid = 0;
    chk("done_seen", done, 1);
    chk("busy_cmd_ready", busy_rdy, 0);
    if (done) last_status = pending_status;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic [7:0]    len;
    bit            wr;
    int            m, last_idx, base, t;

    #23;
    chk("rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY, WLAST, done}, 0);
    chk("rst_addr_len", {AWADDR, AWLEN, ARADDR, ARLEN}, 0);
    chk("rst_wdata", WDATA, 0);
    chk("rst_status", {resp, len_err}, 0);
    @(posedge ACLK); #3 ARESETn = 1;
    @(negedge ACLK);
    chk("rst_cmd_ready", cmd_ready, 1);

    all_ready = 1;
    plan_write(10'h010, 8'd3, 1, 2'b00);
    send_cmd(1, 10'h010, 8'd3); wait_done();

    all_ready = 0;
    plan_read(10'h100, 8'd7, 7, 1, 32'h0);
    send_cmd(0, 10'h100, 8'd7); wait_done();

    aw_stall = 10;
    plan_write(10'h2C4, 8'd2, 0, 2'b00);
    send_cmd(1, 10'h2C4, 8'd2); wait_done();
    chk("aw_stall_consumed", aw_stall, 0);

    plan_read(10'h040, 8'd3, 1, 1, 32'h8);
    send_cmd(0, 10'h040, 8'd3); wait_done();

    plan_write(10'h3FC, 8'd0, 0, 2'b10);
    send_cmd(1, 10'h3FC, 8'd0); wait_done();
    plan_read(10'h004, 8'd0, 0, 0, 32'h0);
    send_cmd(0, 10'h004, 8'd0); wait_done();

    // Reset partway through a write burst
    plan_write(10'h080, 8'd7, 0, 2'b00);
    send_cmd(1, 10'h080, 8'd7);
    base = w_hs_cnt; t = 0;
    while (w_hs_cnt < base + 2 && t < 500) begin @(negedge ACLK); t++; end
    chk("rst_mid_reached", w_hs_cnt >= base + 2, 1);
    #1 ARESETn = 0; cmd_valid = 0;
    #1 chk("rst_async_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY, done}, 0);
    @(posedge ACLK); #2;
    exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_rd.delete(); exp_done.delete();
    last_status = 3'b000;
    @(posedge ACLK); #3 ARESETn = 1;
    @(negedge ACLK);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      chk("rst_mid_no_done", done, 0);
      @(negedge ACLK);
    end

    for (int k = 0; k < 40; k++) begin
      wr = ($urandom_range(0, 1) != 0);
      a = AW'($urandom);
      len = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 15));
      all_ready = ($urandom_range(0, 5) == 0);
      if (wr) plan_write(a, len, 0, 2'($urandom_range(0, 3)));
      else begin
        m = $urandom_range(0, 3);
        if (m == 0 && len > 0) last_idx = $urandom_range(0, int'(len) - 1);
        else if (m == 1) last_idx = int'(len) + $urandom_range(1, 3);
        else last_idx = int'(len);
        plan_read(a, len, last_idx, 0, 32'h0);
      end
      send_cmd(wr, a, len);
      wait_done();
    end

    repeat (3) @(negedge ACLK);
    chk("queues_drained", exp_aw.size() + exp_w.size() + exp_ar.size() + exp_rd.size() + exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
